// File: rtl/mel_patch_pkg.sv
// Shared types and default geometry for the log-mel patch buffer.
// Module-local geometry is recomputed from parameters with the helpers below.
package mel_patch_pkg;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam int DEF_MEL_BINS   = 40;
  localparam int DEF_NUM_FRAMES = 32;
  localparam int DEF_OW         = 16;

  localparam int SLOTS = DEF_NUM_FRAMES + 1;
  localparam int DEPTH = SLOTS * DEF_MEL_BINS;
  localparam int AW    = $clog2(DEPTH);

  function automatic int slots_of(input int num_frames);
    return num_frames + 1;
  endfunction

  function automatic int depth_of(input int num_frames, input int mel_bins);
    return slots_of(num_frames) * mel_bins;
  endfunction

endpackage

// File: rtl/mel_patch_ram.sv
// Simple dual-port frame store: one write port, one read port with a registered output.
// Contents are deliberately not reset so the array maps onto block RAM.
module mel_patch_ram
  import mel_patch_pkg::*;
#(
  parameter int RAM_DEPTH = DEPTH,
  parameter int RAM_W     = DEF_OW,
  parameter int RAM_AW    = AW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [RAM_AW-1:0] i_waddr,
  input  logic [RAM_W-1:0]  i_wdata,
  input  logic              i_re,
  input  logic [RAM_AW-1:0] i_raddr,
  output logic [RAM_W-1:0]  o_rdata
);

  logic [RAM_W-1:0] r_mem [RAM_DEPTH];
  logic [RAM_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mel_patch_buffer.sv
// Circular store of log-mel frames; streams the newest NUM_FRAMES frames, oldest first,
// every STRIDE good frames. One spare slot lets capture continue while a patch drains.
module mel_patch_buffer
  import mel_patch_pkg::*;
#(
  parameter int MEL_BINS   = DEF_MEL_BINS,
  parameter int NUM_FRAMES = DEF_NUM_FRAMES,
  parameter int OW         = DEF_OW,
  parameter int STRIDE     = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [OW-1:0] mel_in,
  input  logic          mel_valid,
  input  logic          mel_frame_done,
  output logic [OW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last,
  output logic          frame_err,
  output logic          frame_dropped,
  output logic          patch_skipped
);

  localparam int N_SLOTS = slots_of(NUM_FRAMES);
  localparam int N_DEPTH = depth_of(NUM_FRAMES, MEL_BINS);
  localparam int N_AW    = $clog2(N_DEPTH);
  localparam int SW      = $clog2(N_SLOTS);   // also wide enough for fill/frame counts
  localparam int BW      = $clog2(MEL_BINS + 1);
  localparam int CW      = $clog2(STRIDE + 1);
  localparam int TOTAL   = NUM_FRAMES * MEL_BINS;
  localparam int IW      = $clog2(TOTAL + 1);

  localparam logic [SW-1:0] SLOT_MAX = SW'(N_SLOTS - 1);
  localparam logic [SW-1:0] FILL_MAX = SW'(NUM_FRAMES);
  localparam logic [SW:0]   OFF_NF   = (SW+1)'(NUM_FRAMES);
  localparam logic [SW:0]   OFF_WRAP = (SW+1)'(N_SLOTS);
  localparam logic [BW-1:0] BINS     = BW'(MEL_BINS);
  localparam logic [BW-1:0] BIN_MAX  = BW'(MEL_BINS - 1);
  localparam logic [BW:0]   BINS_X   = (BW+1)'(MEL_BINS);
  localparam logic [CW-1:0] STRIDE_C = CW'(STRIDE);
  localparam logic [IW-1:0] IDX_MAX  = IW'(TOTAL - 1);

  function automatic logic [SW-1:0] f_slot_inc(input logic [SW-1:0] s);
    return (s == SLOT_MAX) ? '0 : s + 1'b1;
  endfunction

  state_t r_state, w_state_next;

  logic [BW-1:0] r_bin_cnt;
  logic          r_in_frame, r_over, r_drop;
  logic [SW-1:0] r_wr_slot, r_fill;
  logic [CW-1:0] r_stride_cnt;
  logic          r_frame_err, r_frame_dropped, r_patch_skipped;

  logic [SW-1:0] r_start_slot, r_rd_slot, r_acc_frame;
  logic [BW-1:0] r_rd_bin, r_acc_bin;
  logic [IW-1:0] r_rd_idx;
  logic          r_rd_active, r_pend, r_pend_first, r_pend_last;

  logic [OW-1:0] r_out_data, r_skid_data;
  logic          r_out_valid, r_out_first, r_out_last;
  logic          r_skid_valid, r_skid_first, r_skid_last;

  logic          w_first, w_conflict, w_dropping, w_we, w_good, w_commit, w_bad;
  logic [SW:0]   w_off;
  logic [BW:0]   w_total;
  logic [SW-1:0] w_fill_next, w_wr_slot_next;
  logic [CW-1:0] w_stride_next;
  logic          w_trigger, w_pop, w_last_acc, w_busy, w_start, w_skip, w_issue;
  logic [1:0]    w_occ;
  logic [N_AW-1:0] w_waddr, w_raddr;
  logic [OW-1:0] w_rdata;

  // Offset of the write slot from the patch's oldest slot; slots the reader has not
  // yet handed downstream in full must not be overwritten.
  assign w_off      = (r_wr_slot >= r_start_slot) ? ({1'b0, r_wr_slot} - {1'b0, r_start_slot})
                                                  : ({1'b0, r_wr_slot} + OFF_WRAP - {1'b0, r_start_slot});
  assign w_first    = mel_valid && !r_in_frame;
  assign w_conflict = w_first && (r_state == EMIT) && (w_off < OFF_NF) && (w_off >= {1'b0, r_acc_frame});
  assign w_dropping = r_drop || w_conflict;
  assign w_we       = mel_valid && !w_dropping && (r_bin_cnt != BINS);
  assign w_waddr    = N_AW'(int'(r_wr_slot) * MEL_BINS + int'(r_bin_cnt));

  // The final sample arrives together with mel_frame_done, so it counts toward the total.
  assign w_total  = {1'b0, r_bin_cnt} + {{BW{1'b0}}, mel_valid};
  assign w_good   = !r_over && (w_total == BINS_X);
  assign w_commit = mel_frame_done && !w_dropping && w_good;
  assign w_bad    = mel_frame_done && !w_dropping && !w_good;

  assign w_wr_slot_next = f_slot_inc(r_wr_slot);
  assign w_fill_next    = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  assign w_stride_next  = (r_stride_cnt == STRIDE_C) ? r_stride_cnt : r_stride_cnt + 1'b1;
  assign w_trigger      = w_commit && (w_fill_next == FILL_MAX) && (w_stride_next == STRIDE_C);

  assign w_pop      = r_out_valid && out_ready;
  assign w_last_acc = w_pop && r_out_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_trigger) w_state_next = EMIT;
      EMIT: if (w_last_acc && !w_trigger) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // A commit coinciding with the final accept sees the FSM as already idle.
  always_comb begin
    w_busy  = (r_state == EMIT) && !w_last_acc;
    w_start = w_trigger && !w_busy;
    w_skip  = w_trigger && w_busy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin_cnt       <= '0;
      r_in_frame      <= 1'b0;
      r_over          <= 1'b0;
      r_drop          <= 1'b0;
      r_wr_slot       <= '0;
      r_fill          <= '0;
      r_stride_cnt    <= '0;
      r_frame_err     <= 1'b0;
      r_frame_dropped <= 1'b0;
      r_patch_skipped <= 1'b0;
    end else begin
      r_frame_err     <= w_bad;
      r_frame_dropped <= mel_frame_done && w_dropping;
      r_patch_skipped <= w_skip;
      if (mel_valid) begin
        r_in_frame <= 1'b1;
        r_drop     <= w_dropping;
        if (r_bin_cnt == BINS) r_over <= 1'b1;
      end
      if (w_we) r_bin_cnt <= r_bin_cnt + 1'b1;
      if (mel_frame_done) begin
        r_in_frame <= 1'b0;
        r_over     <= 1'b0;
        r_drop     <= 1'b0;
        r_bin_cnt  <= '0;
      end
      if (w_commit) begin
        r_wr_slot    <= w_wr_slot_next;
        r_fill       <= w_fill_next;
        r_stride_cnt <= w_trigger ? '0 : w_stride_next;
      end
    end
  end

  // Credit check keeps at most two words between RAM output and the skid stage.
  assign w_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid} + {1'b0, r_pend};
  assign w_issue = r_rd_active && (w_occ < (2'd2 + {1'b0, w_pop}));
  assign w_raddr = N_AW'(int'(r_rd_slot) * MEL_BINS + int'(r_rd_bin));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_slot <= '0;
      r_rd_slot    <= '0;
      r_rd_bin     <= '0;
      r_rd_idx     <= '0;
      r_rd_active  <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_first <= 1'b0;
      r_pend_last  <= 1'b0;
      r_acc_frame  <= '0;
      r_acc_bin    <= '0;
    end else begin
      r_pend       <= w_issue;
      r_pend_first <= w_issue && (r_rd_idx == '0);
      r_pend_last  <= w_issue && (r_rd_idx == IDX_MAX);
      if (w_issue) begin
        r_rd_idx <= r_rd_idx + 1'b1;
        if (r_rd_idx == IDX_MAX) r_rd_active <= 1'b0;
        if (r_rd_bin == BIN_MAX) begin
          r_rd_bin  <= '0;
          r_rd_slot <= f_slot_inc(r_rd_slot);
        end else begin
          r_rd_bin <= r_rd_bin + 1'b1;
        end
      end
      if (w_pop) begin
        if (r_acc_bin == BIN_MAX) begin
          r_acc_bin   <= '0;
          r_acc_frame <= r_acc_frame + 1'b1;
        end else begin
          r_acc_bin <= r_acc_bin + 1'b1;
        end
      end
      if (w_start) begin
        r_start_slot <= f_slot_inc(w_wr_slot_next);
        r_rd_slot    <= f_slot_inc(w_wr_slot_next);
        r_rd_bin     <= '0;
        r_rd_idx     <= '0;
        r_rd_active  <= 1'b1;
        r_acc_frame  <= '0;
        r_acc_bin    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_first  <= 1'b0;
      r_out_last   <= 1'b0;
      r_skid_data  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_first <= 1'b0;
      r_skid_last  <= 1'b0;
    end else if (!r_out_valid || w_pop) begin
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_out_first  <= r_skid_first;
        r_out_last   <= r_skid_last;
        r_skid_valid <= r_pend;
        r_skid_data  <= w_rdata;
        r_skid_first <= r_pend_first;
        r_skid_last  <= r_pend_last;
      end else begin
        r_out_data  <= w_rdata;
        r_out_valid <= r_pend;
        r_out_first <= r_pend_first;
        r_out_last  <= r_pend_last;
      end
    end else if (r_pend) begin
      r_skid_valid <= 1'b1;
      r_skid_data  <= w_rdata;
      r_skid_first <= r_pend_first;
      r_skid_last  <= r_pend_last;
    end
  end

  mel_patch_ram #(
    .RAM_DEPTH(N_DEPTH),
    .RAM_W    (OW),
    .RAM_AW   (N_AW)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(mel_in),
    .i_re   (w_issue),
    .i_raddr(w_raddr),
    .o_rdata(w_rdata)
  );

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_first     = r_out_first;
  assign out_last      = r_out_last;
  assign frame_err     = r_frame_err;
  assign frame_dropped = r_frame_dropped;
  assign patch_skipped = r_patch_skipped;

endmodule
